// File: rtl/dac_run_sequencer.sv
// dac_run_sequencer
//
// Run-control sequencer for the DAC/ADC acquisition path in the clk_50 domain.
// A run goes IDLE -> ARM (wait for the ADC front end) -> SETTLE (DAC enabled,
// settle countdown) -> RUN (optional FIFO writes) -> STOP (wait for the
// 125 MHz side to acknowledge DAC_running low) -> IDLE.
//
// Ports
//   clk_50          : single clock
//   reset_n         : synchronous active-low reset
//   start_dac_cmd   : pulse, start a run (honoured only in IDLE)
//   start_fifo_cmd  : pulse, arm FIFO writes (honoured in ARM/SETTLE/RUN)
//   stop_dac_cmd    : pulse, end the run (honoured in ARM/SETTLE/RUN)
//   ADC_ready       : level, ADC front end ready
//   DAC_running_fb  : level, DAC_running returned from the 125 MHz domain
//   settle_cycles   : DAC settle time in cycles before RUN
//   run_length      : FIFO write cycles per run, 0 = unlimited
//   DAC_running     : registered run level to the 125 MHz domain
//   dac_enable      : registered DAC output-stage enable
//   fifo_wr_en      : registered FIFO write enable
//   sample_count    : FIFO write cycles in the current/last run (saturating)
//   busy            : state is not IDLE
//   done            : one-cycle pulse on STOP -> IDLE
//   error_code      : 0 none, 1 ADC timeout, 2 ADC lost, 3 feedback timeout
module dac_run_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 50000000,
  parameter int unsigned CNT_W          = 32
) (
  input  logic             clk_50,
  input  logic             reset_n,
  input  logic             start_dac_cmd,
  input  logic             start_fifo_cmd,
  input  logic             stop_dac_cmd,
  input  logic             ADC_ready,
  input  logic             DAC_running_fb,
  input  logic [15:0]      settle_cycles,
  input  logic [CNT_W-1:0] run_length,
  output logic             DAC_running,
  output logic             dac_enable,
  output logic             fifo_wr_en,
  output logic [CNT_W-1:0] sample_count,
  output logic             busy,
  output logic             done,
  output logic [1:0]       error_code
);

  localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_ADC_TO   = 2'd1;
  localparam logic [1:0] ERR_ADC_LOST = 2'd2;
  localparam logic [1:0] ERR_FB_TO    = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARM    = 3'd1,
    S_SETTLE = 3'd2,
    S_RUN    = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [TO_W-1:0]    r_timeout;
  logic [15:0]        r_settle_cnt;
  logic               r_fifo_armed;
  logic               w_fifo_armed_nxt;
  logic               r_dac_running;
  logic               r_dac_enable;
  logic               r_fifo_wr_en;
  logic [CNT_W-1:0]   r_sample_count;
  logic               r_done;
  logic [1:0]         r_error;
  logic               w_err_set;
  logic [1:0]         w_err_val;
  logic               w_to_expired;
  logic               w_last_write;
  logic               w_start;
  logic               w_active;
  logic               w_settle_done;

  assign w_to_expired = (r_timeout == TO_LAST);
  assign w_start      = (r_state == S_IDLE) && start_dac_cmd;
  assign w_active     = (r_state == S_ARM) || (r_state == S_SETTLE) || (r_state == S_RUN);

  // The counter is decremented on the edge that leaves SETTLE, so leaving when
  // it holds 1 (or 0) gives settle_cycles SETTLE cycles, with a floor of one.
  assign w_settle_done = (r_settle_cnt <= 16'd1);

  // This write is the one that brings sample_count up to run_length.
  assign w_last_write = r_fifo_wr_en && (run_length != '0) &&
                        (r_sample_count == (run_length - CNT_W'(1)));

  // State register
  always_ff @(posedge clk_50) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; stop always takes priority over other run conditions.
  always_comb begin
    w_state_nxt      = r_state;
    w_err_set        = 1'b0;
    w_err_val        = ERR_NONE;
    w_fifo_armed_nxt = r_fifo_armed;
    case (r_state)
      S_IDLE: begin
        if (start_dac_cmd) w_state_nxt = S_ARM;
      end
      S_ARM: begin
        if (stop_dac_cmd) begin
          w_state_nxt = S_STOP;
        end else if (ADC_ready) begin
          w_state_nxt = S_SETTLE;
        end else if (w_to_expired) begin
          w_state_nxt = S_STOP;
          w_err_set   = 1'b1;
          w_err_val   = ERR_ADC_TO;
        end
      end
      S_SETTLE: begin
        if (stop_dac_cmd) begin
          w_state_nxt = S_STOP;
        end else if (w_settle_done) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (stop_dac_cmd) begin
          w_state_nxt = S_STOP;
        end else if (!ADC_ready) begin
          w_state_nxt = S_STOP;
          w_err_set   = 1'b1;
          w_err_val   = ERR_ADC_LOST;
        end else if (w_last_write) begin
          w_state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (!DAC_running_fb) begin
          w_state_nxt = S_IDLE;
        end else if (w_to_expired) begin
          w_state_nxt = S_IDLE;
          w_err_set   = 1'b1;
          w_err_val   = ERR_FB_TO;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    if (start_fifo_cmd && w_active) w_fifo_armed_nxt = 1'b1;
    if (w_state_nxt == S_IDLE)      w_fifo_armed_nxt = 1'b0;
  end

  // Counters and registered outputs, all derived from the next state so the
  // outputs line up with the state they describe.
  always_ff @(posedge clk_50) begin
    if (!reset_n) begin
      r_timeout      <= '0;
      r_settle_cnt   <= '0;
      r_fifo_armed   <= 1'b0;
      r_dac_running  <= 1'b0;
      r_dac_enable   <= 1'b0;
      r_fifo_wr_en   <= 1'b0;
      r_sample_count <= '0;
      r_done         <= 1'b0;
      r_error        <= ERR_NONE;
    end else begin
      if (w_state_nxt != r_state) begin
        r_timeout <= '0;
      end else if (((r_state == S_ARM) || (r_state == S_STOP)) && !w_to_expired) begin
        r_timeout <= r_timeout + TO_W'(1);
      end

      if ((r_state == S_ARM) && (w_state_nxt == S_SETTLE)) begin
        r_settle_cnt <= settle_cycles;
      end else if ((r_state == S_SETTLE) && (r_settle_cnt != 16'd0)) begin
        r_settle_cnt <= r_settle_cnt - 16'd1;
      end

      r_fifo_armed  <= w_fifo_armed_nxt;
      r_dac_running <= (w_state_nxt == S_SETTLE) || (w_state_nxt == S_RUN);
      r_dac_enable  <= (w_state_nxt == S_SETTLE) || (w_state_nxt == S_RUN);
      r_fifo_wr_en  <= (w_state_nxt == S_RUN) && w_fifo_armed_nxt;

      if (w_start) begin
        r_sample_count <= '0;
      end else if (r_fifo_wr_en && (r_sample_count != '1)) begin
        r_sample_count <= r_sample_count + CNT_W'(1);
      end

      r_done <= (r_state == S_STOP) && (w_state_nxt == S_IDLE);

      // Only the first error of a run is kept.
      if (w_start) begin
        r_error <= ERR_NONE;
      end else if (w_err_set && (r_error == ERR_NONE)) begin
        r_error <= w_err_val;
      end
    end
  end

  assign DAC_running  = r_dac_running;
  assign dac_enable   = r_dac_enable;
  assign fifo_wr_en   = r_fifo_wr_en;
  assign sample_count = r_sample_count;
  assign busy         = (r_state != S_IDLE);
  assign done         = r_done;
  assign error_code   = r_error;

endmodule

// File: tb/tb_dac_run_sequencer.sv
module tb_dac_run_sequencer;

  localparam int unsigned TO    = 16;
  localparam int unsigned CNT_W = 8;

  logic             clk_50;
  logic             reset_n;
  logic             start_dac_cmd;
  logic             start_fifo_cmd;
  logic             stop_dac_cmd;
  logic             ADC_ready;
  logic             DAC_running_fb;
  logic [15:0]      settle_cycles;
  logic [CNT_W-1:0] run_length;
  logic             DAC_running;
  logic             dac_enable;
  logic             fifo_wr_en;
  logic [CNT_W-1:0] sample_count;
  logic             busy;
  logic             done;
  logic [1:0]       error_code;

  // Round trip through the fast domain modelled as a two-cycle delay,
  // with an override that holds the feedback high.
  logic [1:0] fb_pipe = 2'b00;
  logic       fb_hold;

  int n_chk  = 0;
  int n_pass = 0;

  dac_run_sequencer #(
    .TIMEOUT_CYCLES(TO),
    .CNT_W(CNT_W)
  ) dut (
    .clk_50(clk_50),
    .reset_n(reset_n),
    .start_dac_cmd(start_dac_cmd),
    .start_fifo_cmd(start_fifo_cmd),
    .stop_dac_cmd(stop_dac_cmd),
    .ADC_ready(ADC_ready),
    .DAC_running_fb(DAC_running_fb),
    .settle_cycles(settle_cycles),
    .run_length(run_length),
    .DAC_running(DAC_running),
    .dac_enable(dac_enable),
    .fifo_wr_en(fifo_wr_en),
    .sample_count(sample_count),
    .busy(busy),
    .done(done),
    .error_code(error_code)
  );

  initial clk_50 = 1'b0;
  always #5 clk_50 = ~clk_50;

  always @(posedge clk_50) fb_pipe <= {fb_pipe[0], DAC_running};
  assign DAC_running_fb = fb_hold | fb_pipe[1];

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clk_50);
    #1;
  endtask

  task automatic wait_idle(input int budget, output int n_run, output int n_wr, output int n_done);
    n_run  = 0;
    n_wr   = 0;
    n_done = 0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (DAC_running) n_run++;
      if (fifo_wr_en)  n_wr++;
      if (done)        n_done++;
      if (!busy) break;
    end
    chk_eq("reach_idle", 32'(busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n_run, n_wr, n_done, any_run;
    reset_n        = 1'b0;
    start_dac_cmd  = 1'b0;
    start_fifo_cmd = 1'b0;
    stop_dac_cmd   = 1'b0;
    ADC_ready      = 1'b1;
    fb_hold        = 1'b0;
    settle_cycles  = 16'd0;
    run_length     = '0;

    // Reset state
    tick();
    tick();
    chk_eq("rst_busy", 32'(busy), 0);
    chk_eq("rst_run", 32'(DAC_running), 0);
    chk_eq("rst_en", 32'(dac_enable), 0);
    chk_eq("rst_wr", 32'(fifo_wr_en), 0);
    chk_eq("rst_done", 32'(done), 0);
    chk_eq("rst_cnt", 32'(sample_count), 0);
    chk_eq("rst_err", 32'(error_code), 0);
    reset_n = 1'b1;
    tick();

    // Nominal run: settle 3, run_length 5, FIFO armed during SETTLE
    settle_cycles = 16'd3;
    run_length    = 8'd5;
    start_dac_cmd = 1'b1;
    tick();
    start_dac_cmd = 1'b0;
    chk_eq("nom_arm_busy", 32'(busy), 1);
    chk_eq("nom_arm_run", 32'(DAC_running), 0);
    tick();
    chk_eq("nom_settle_run", 32'(DAC_running), 1);
    chk_eq("nom_settle_en", 32'(dac_enable), 1);
    start_fifo_cmd = 1'b1;
    tick();
    start_fifo_cmd = 1'b0;
    chk_eq("nom_settle_wr", 32'(fifo_wr_en), 0);
    wait_idle(60, n_run, n_wr, n_done);
    chk_eq("nom_settle_cycles", 2 + n_run - n_wr, 3);
    chk_eq("nom_writes", n_wr, 5);
    chk_eq("nom_count", 32'(sample_count), 5);
    chk_eq("nom_done", n_done, 1);
    chk_eq("nom_err", 32'(error_code), 0);
    tick();
    chk_eq("nom_done_1cyc", 32'(done), 0);

    // ADC timeout: 16 cycles in ARM, then error 1
    ADC_ready     = 1'b0;
    start_dac_cmd = 1'b1;
    tick();
    start_dac_cmd = 1'b0;
    any_run = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (DAC_running) any_run++;
    end
    chk_eq("ato_err_before", 32'(error_code), 0);
    chk_eq("ato_busy_before", 32'(busy), 1);
    tick();
    chk_eq("ato_err", 32'(error_code), 1);
    wait_idle(40, n_run, n_done, n_done);
    chk_eq("ato_done", 32'(done), 1);
    chk_eq("ato_never_run", any_run + n_run, 0);
    chk_eq("ato_err_persist", 32'(error_code), 1);
    ADC_ready = 1'b1;
    tick();

    // Unlimited run, settle 0, stop after 10 writes
    settle_cycles = 16'd0;
    run_length    = '0;
    start_dac_cmd = 1'b1;
    tick();
    start_dac_cmd  = 1'b0;
    chk_eq("unl_err_clear", 32'(error_code), 0);
    start_fifo_cmd = 1'b1;
    tick();
    start_fifo_cmd = 1'b0;
    chk_eq("unl_settle_run", 32'(DAC_running), 1);
    chk_eq("unl_settle_wr", 32'(fifo_wr_en), 0);
    tick();
    chk_eq("unl_wr_first", 32'(fifo_wr_en), 1);
    chk_eq("unl_cnt_first", 32'(sample_count), 0);
    repeat (9) tick();
    chk_eq("unl_cnt9", 32'(sample_count), 9);
    stop_dac_cmd = 1'b1;
    tick();
    stop_dac_cmd = 1'b0;
    chk_eq("unl_cnt10", 32'(sample_count), 10);
    chk_eq("unl_wr_off", 32'(fifo_wr_en), 0);
    chk_eq("unl_run_off", 32'(DAC_running), 0);
    chk_eq("unl_stop_busy", 32'(busy), 1);
    wait_idle(40, n_run, n_wr, n_done);
    chk_eq("unl_done", n_done, 1);
    chk_eq("unl_err", 32'(error_code), 0);

    // Collisions: start+stop in RUN, then start during STOP
    start_dac_cmd = 1'b1;
    tick();
    start_dac_cmd = 1'b0;
    tick();
    tick();
    chk_eq("col_in_run", 32'(DAC_running), 1);
    fb_hold       = 1'b1;
    start_dac_cmd = 1'b1;
    stop_dac_cmd  = 1'b1;
    tick();
    start_dac_cmd = 1'b0;
    stop_dac_cmd  = 1'b0;
    chk_eq("col_stop_run", 32'(DAC_running), 0);
    chk_eq("col_stop_busy", 32'(busy), 1);
    start_dac_cmd = 1'b1;
    tick();
    start_dac_cmd = 1'b0;
    chk_eq("col_start_ign", 32'(DAC_running), 0);
    fb_hold = 1'b0;
    wait_idle(40, n_run, n_wr, n_done);
    chk_eq("col_no_rerun", n_run, 0);
    chk_eq("col_done_once", n_done, 1);
    repeat (4) tick();
    chk_eq("col_stay_idle", 32'(busy), 0);

    // Fault: ADC lost in RUN, feedback stuck high
    start_dac_cmd = 1'b1;
    tick();
    start_dac_cmd = 1'b0;
    tick();
    tick();
    fb_hold   = 1'b1;
    ADC_ready = 1'b0;
    tick();
    ADC_ready = 1'b1;
    chk_eq("flt_err2", 32'(error_code), 2);
    chk_eq("flt_run_off", 32'(DAC_running), 0);
    repeat (15) tick();
    chk_eq("flt_stop_hold", 32'(busy), 1);
    tick();
    chk_eq("flt_idle", 32'(busy), 0);
    chk_eq("flt_done", 32'(done), 1);
    chk_eq("flt_err_stays2", 32'(error_code), 2);
    fb_hold = 1'b0;
    repeat (3) tick();

    // Reset mid-RUN, then a fresh run with FIFO armed during RUN
    start_dac_cmd = 1'b1;
    tick();
    start_dac_cmd  = 1'b0;
    start_fifo_cmd = 1'b1;
    tick();
    start_fifo_cmd = 1'b0;
    tick();
    tick();
    tick();
    chk_eq("mr_pre_wr", 32'(fifo_wr_en), 1);
    reset_n = 1'b0;
    tick();
    chk_eq("mr_run", 32'(DAC_running), 0);
    chk_eq("mr_en", 32'(dac_enable), 0);
    chk_eq("mr_wr", 32'(fifo_wr_en), 0);
    chk_eq("mr_busy", 32'(busy), 0);
    chk_eq("mr_cnt", 32'(sample_count), 0);
    chk_eq("mr_done", 32'(done), 0);
    reset_n = 1'b1;
    n_done = 0;
    repeat (4) begin
      tick();
      if (done) n_done++;
    end
    chk_eq("mr_no_done", n_done, 0);
    settle_cycles = 16'd1;
    run_length    = 8'd3;
    start_dac_cmd = 1'b1;
    tick();
    start_dac_cmd = 1'b0;
    tick();
    tick();
    tick();
    chk_eq("mr2_in_run", 32'(DAC_running), 1);
    chk_eq("mr2_armed_clr", 32'(fifo_wr_en), 0);
    start_fifo_cmd = 1'b1;
    tick();
    start_fifo_cmd = 1'b0;
    chk_eq("mr2_wr_next", 32'(fifo_wr_en), 1);
    wait_idle(40, n_run, n_wr, n_done);
    chk_eq("mr2_writes", n_wr + 1, 3);
    chk_eq("mr2_cnt", 32'(sample_count), 3);
    chk_eq("mr2_done", n_done, 1);
    chk_eq("mr2_err", 32'(error_code), 0);

    // Saturation of sample_count in an unlimited run
    settle_cycles = 16'd0;
    run_length    = '0;
    start_dac_cmd = 1'b1;
    tick();
    start_dac_cmd  = 1'b0;
    start_fifo_cmd = 1'b1;
    tick();
    start_fifo_cmd = 1'b0;
    repeat (300) tick();
    chk_eq("sat_cnt", 32'(sample_count), 255);
    chk_eq("sat_wr", 32'(fifo_wr_en), 1);
    stop_dac_cmd = 1'b1;
    tick();
    stop_dac_cmd = 1'b0;
    wait_idle(40, n_run, n_wr, n_done);
    chk_eq("sat_cnt_end", 32'(sample_count), 255);
    chk_eq("sat_done", n_done, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
